// File: rtl/arm_fifo_reader_if.sv
// Bundle of the ARM FIFO handshake and the asynchronous ARM register-read bus.
// The reader uses the slave modport; the FIFO/ARM side uses the master modport.
interface arm_fifo_reader_if;
  logic [9:0]  armfifo_q;
  logic        armfifo_empty;
  logic        armfifo_full;
  logic        armfifo_rdreq;
  logic        dout_enable;
  logic        arm_cs_n;
  logic        arm_rd_n;
  logic [1:0]  arm_addr;
  logic [15:0] arm_data;
  logic        arm_irq;

  modport slave (
    input  armfifo_q, armfifo_empty, armfifo_full, arm_cs_n, arm_rd_n, arm_addr,
    output armfifo_rdreq, dout_enable, arm_data, arm_irq
  );

  modport master (
    output armfifo_q, armfifo_empty, armfifo_full, arm_cs_n, arm_rd_n, arm_addr,
    input  armfifo_rdreq, dout_enable, arm_data, arm_irq
  );
endinterface

// File: rtl/arm_fifo_reader.sv
// Hands one averaged frame from the ARM FIFO to the ARM word by word: each word is
// fetched, raised as an interrupt, and popped by an ARM read of register 0.
module arm_fifo_reader #(
  parameter int FRAME_LEN = 8192,
  parameter int CNT_W     = 14
) (
  input  logic               clk,
  input  logic               reset,
  arm_fifo_reader_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_READY,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_cs_sync;
  logic [1:0]        r_rd_sync;
  logic [1:0]        r_addr_s1;
  logic [1:0]        r_addr_s2;
  logic              r_rd_prev;
  logic [9:0]        r_rd_data;
  logic [CNT_W-1:0]  r_word_cnt;
  logic [15:0]       r_frame_cnt;
  logic              r_underrun;
  logic              r_dout_enable;
  logic [15:0]       r_arm_data;
  logic              w_pop;
  logic              w_last;
  logic              w_rdreq;
  logic              w_ready;
  logic [11:0]       w_cnt_lo;

  // Strobes idle high, so their synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cs_sync <= 2'b11;
      r_rd_sync <= 2'b11;
      r_rd_prev <= 1'b1;
      r_addr_s1 <= 2'd0;
      r_addr_s2 <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
      // which is what makes this a true two-stage synchronizer chain.
      r_cs_sync <= {r_cs_sync[0], bus.arm_cs_n};
      r_rd_sync <= {r_rd_sync[0], bus.arm_rd_n};
      r_rd_prev <= r_rd_sync[1];
      r_addr_s1 <= bus.arm_addr;
      r_addr_s2 <= r_addr_s1;
    end
  end

  assign w_pop    = r_rd_sync[1] & ~r_rd_prev & ~r_cs_sync[1] & (r_addr_s2 == 2'd0);
  assign w_last   = (r_word_cnt == CNT_W'(FRAME_LEN - 1));
  assign w_cnt_lo = 12'(r_word_cnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.armfifo_full) w_next = S_FETCH;
      S_FETCH: w_next = bus.armfifo_empty ? S_DONE : S_LATCH;
      S_LATCH: w_next = S_READY;
      S_READY: if (w_pop) w_next = w_last ? S_DONE : S_FETCH;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_rdreq = 1'b0;
    w_ready = 1'b0;
    case (r_state)
      S_FETCH: w_rdreq = ~bus.armfifo_empty;
      S_READY: w_ready = 1'b1;
      default: ;
    endcase
  end

  // Datapath and registered bus outputs; dout_enable is registered so it stays
  // low through reset and rises on the first clock after release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_data     <= '0;
      r_word_cnt    <= '0;
      r_frame_cnt   <= '0;
      r_underrun    <= 1'b0;
      r_dout_enable <= 1'b0;
      r_arm_data    <= '0;
    end else begin
      r_dout_enable <= (w_next == S_IDLE);
      case (r_state)
        S_FETCH: if (bus.armfifo_empty) r_underrun <= 1'b1;
        S_LATCH: r_rd_data <= bus.armfifo_q;
        S_READY: if (w_pop && !w_last) r_word_cnt <= r_word_cnt + 1'b1;
        S_DONE: begin
          r_word_cnt  <= '0;
          r_frame_cnt <= r_frame_cnt + 16'd1;
        end
        default: ;
      endcase
      case (r_addr_s2)
        2'd0:    r_arm_data <= {6'b0, r_rd_data};
        2'd1:    r_arm_data <= {r_underrun, w_ready, bus.armfifo_empty,
                                bus.armfifo_full, w_cnt_lo};
        2'd2:    r_arm_data <= r_frame_cnt;
        default: r_arm_data <= 16'h0000;
      endcase
    end
  end

  assign bus.armfifo_rdreq = w_rdreq;
  assign bus.arm_irq       = w_ready;
  assign bus.dout_enable   = r_dout_enable;
  assign bus.arm_data      = r_arm_data;

endmodule

// File: tb/tb_arm_fifo_reader.sv
// Directed-sequence bench for arm_fifo_reader with FRAME_LEN = 4, random frame
// payloads, a queue-based FIFO stand-in and a frame-level expectation model.
module tb_arm_fifo_reader;
  localparam int FRAME_LEN = 4;

  logic clk;
  logic reset;
  arm_fifo_reader_if bus ();

  arm_fifo_reader #(.FRAME_LEN(FRAME_LEN), .CNT_W(14)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO stand-in: show-ahead-free, data valid the clock after the pop request.
  logic [9:0] fifo_q[$];
  always @(posedge clk) begin
    if (bus.armfifo_rdreq && fifo_q.size() != 0) bus.armfifo_q <= fifo_q.pop_front();
  end

  // Pop-request monitor: total count and minimum spacing between requests.
  int n_rdreq   = 0;
  int n_spacing = 0;
  int cyc       = 0;
  int last_rd   = -100;
  always @(negedge clk) begin
    cyc++;
    if (bus.armfifo_rdreq) begin
      n_rdreq++;
      if (cyc - last_rd < 3) n_spacing++;
      last_rd = cyc;
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  // Expectation model: words in frame order, words delivered so far in the
  // current frame, frames completed, pops the reader should have issued.
  logic [9:0] exp_q[$];
  int         exp_cnt      = 0;
  int         exp_frames   = 0;
  int         exp_rdreq    = 0;
  bit         exp_underrun = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_irq(input string tag);
    for (int i = 0; i < 40 && !bus.arm_irq; i++) @(negedge clk);
    check(tag, 32'(bus.arm_irq), 32'd1);
  endtask

  task automatic arm_read(input logic [1:0] a, output logic [15:0] d);
    @(negedge clk);
    bus.arm_cs_n = 1'b0;
    bus.arm_addr = a;
    bus.arm_rd_n = 1'b0;
    repeat (6) @(negedge clk);
    d = bus.arm_data;
    bus.arm_rd_n = 1'b1;
    repeat (6) @(negedge clk);
    bus.arm_cs_n = 1'b1;
    bus.arm_addr = 2'd0;
  endtask

  task automatic load_frame(input bit fixed_words);
    logic [9:0] w;
    for (int i = 0; i < FRAME_LEN; i++) begin
      w = fixed_words ? 10'((i + 1) * 10) : 10'($urandom_range(0, 1023));
      fifo_q.push_back(w);
      exp_q.push_back(w);
    end
    @(negedge clk);
    bus.armfifo_full = 1'b1;
    exp_rdreq++;
    wait_irq("irq_first_word");
    bus.armfifo_full = 1'b0;
  endtask

  task automatic read_word();
    logic [15:0] d;
    logic [9:0]  w;
    w = exp_q.pop_front();
    wait_irq("irq_word");
    arm_read(2'd0, d);
    check("word_data", 32'(d), 32'({6'b0, w}));
    if (exp_cnt == FRAME_LEN - 1) begin
      exp_cnt = 0;
      exp_frames++;
    end else begin
      exp_cnt++;
      exp_rdreq++;
    end
  endtask

  function automatic logic [15:0] status_word(input bit ready);
    return {exp_underrun, ready, 1'b0, 1'b0, 12'(exp_cnt)};
  endfunction

  initial begin
    logic [15:0] d;
    int          snap;

    reset             = 1'b1;
    bus.armfifo_empty = 1'b0;
    bus.armfifo_full  = 1'b0;
    bus.arm_cs_n      = 1'b1;
    bus.arm_rd_n      = 1'b1;
    bus.arm_addr      = 2'd0;

    // Reset state
    @(negedge clk);
    check("rst_dout_enable", 32'(bus.dout_enable), 32'd0);
    check("rst_irq", 32'(bus.arm_irq), 32'd0);
    check("rst_rdreq", 32'(bus.armfifo_rdreq), 32'd0);
    check("rst_arm_data", 32'(bus.arm_data), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("idle_dout_enable", 32'(bus.dout_enable), 32'd1);
    check("idle_irq", 32'(bus.arm_irq), 32'd0);
    check("idle_no_rdreq", 32'(n_rdreq), 32'd0);

    // Frame A: fixed words 10,20,30,40 with status read and rd_n glitch in READY
    load_frame(1'b1);
    check("fetch_dout_off", 32'(bus.dout_enable), 32'd0);
    check("first_rdreq_count", 32'(n_rdreq), 32'(exp_rdreq));
    read_word();
    snap = n_rdreq;
    arm_read(2'd1, d);
    check("status_ready", 32'(d), 32'(status_word(1'b1)));
    check("status_no_pop", 32'(n_rdreq), 32'(snap));
    wait_irq("irq_after_status");
    @(negedge clk);
    bus.arm_rd_n = 1'b0;
    repeat (2) @(negedge clk);
    bus.arm_rd_n = 1'b1;
    repeat (8) @(negedge clk);
    check("glitch_no_pop", 32'(n_rdreq), 32'(snap));
    check("glitch_irq_held", 32'(bus.arm_irq), 32'd1);
    check("glitch_rd_data", 32'(bus.arm_data), 32'(exp_q[0]));
    for (int i = 1; i < FRAME_LEN; i++) read_word();
    repeat (2) @(negedge clk);
    check("frameA_irq_off", 32'(bus.arm_irq), 32'd0);
    check("frameA_dout_enable", 32'(bus.dout_enable), 32'd1);
    check("frameA_rdreq_total", 32'(n_rdreq), 32'(exp_rdreq));
    arm_read(2'd2, d);
    check("frameA_frame_cnt", 32'(d), 32'(exp_frames));
    arm_read(2'd1, d);
    check("frameA_status", 32'(d), 32'(status_word(1'b0)));

    // Frame B: random payload
    load_frame(1'b0);
    for (int i = 0; i < FRAME_LEN; i++) read_word();
    repeat (2) @(negedge clk);
    check("frameB_irq_off", 32'(bus.arm_irq), 32'd0);
    check("frameB_rdreq_total", 32'(n_rdreq), 32'(exp_rdreq));
    arm_read(2'd2, d);
    check("frameB_frame_cnt", 32'(d), 32'(exp_frames));

    // Underrun: full and empty together for a single clock
    snap = n_rdreq;
    @(negedge clk);
    bus.armfifo_full  = 1'b1;
    bus.armfifo_empty = 1'b1;
    @(negedge clk);
    bus.armfifo_full  = 1'b0;
    repeat (5) @(negedge clk);
    bus.armfifo_empty = 1'b0;
    exp_underrun = 1'b1;
    exp_frames++;
    check("underrun_no_rdreq", 32'(n_rdreq), 32'(snap));
    check("underrun_idle", 32'(bus.dout_enable), 32'd1);
    check("underrun_irq", 32'(bus.arm_irq), 32'd0);
    arm_read(2'd1, d);
    check("underrun_status", 32'(d), 32'(status_word(1'b0)));
    arm_read(2'd2, d);
    check("underrun_frame_cnt", 32'(d), 32'(exp_frames));

    // Reset mid-frame after the second pop
    load_frame(1'b0);
    read_word();
    read_word();
    check("midframe_irq", 32'(bus.arm_irq), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset_irq", 32'(bus.arm_irq), 32'd0);
    check("midreset_rdreq", 32'(bus.armfifo_rdreq), 32'd0);
    snap = n_rdreq;
    exp_cnt      = 0;
    exp_frames   = 0;
    exp_underrun = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("postreset_no_rdreq", 32'(n_rdreq), 32'(snap));
    check("postreset_irq", 32'(bus.arm_irq), 32'd0);
    check("postreset_dout_enable", 32'(bus.dout_enable), 32'd1);
    arm_read(2'd1, d);
    check("postreset_status", 32'(d), 32'(status_word(1'b0)));
    arm_read(2'd2, d);
    check("postreset_frame_cnt", 32'(d), 32'(exp_frames));

    check("rdreq_spacing", 32'(n_spacing), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
